reflet_interrupt_nested: RTL and testbench
==========================================

Name: reflet_interrupt_nested

Overview:
Parametrised successor to the 4-line interrupt controller sitting beside the Reflet CPU register file.
- Supports `channels` request lines and fixed priority, where a lower index means a higher priority.
- Supports true nesting: a higher-priority request preempts a running routine.
- Uses an internal return-address stack and per-channel vectored routine addresses.
- Feeds the CPU through the same OR-combined `out`/`out_reg` write-back path and the same `interrupt`/`out_routine` redirect used by the current controller.

Parameters:
- wordsize, 16, CPU word width.
- channels, 4, number of interrupt request lines (1..16); also the maximum nesting depth.
- vector_base, 0, routine address of channel 0.
- vector_stride, 16, address distance between consecutive channel routines.
- pc_id, 1, register index driven on `out_reg` when restoring PC.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  CPU enable; take/return suppressed when low
- interrupt_request  in  channels  level inputs, rising-edge sensitive
- int_mask  in  channels  1 = channel enabled
- cpu_update  in  1  CPU commits an instruction this cycle
- ret_int  in  1  committed instruction is the return-from-interrupt; qualified by cpu_update
- program_counter  in  wordsize  resume address to save on preemption
- interrupt  out  1  redirect the CPU this cycle (combinational)
- out_routine  out  wordsize  routine address, valid when interrupt=1, else 0
- out  out  wordsize  restored PC on a return, else 0
- out_reg  out  4  pc_id on a return, else 0
- in_interrupt_context  out  1  registered; 1 while stack depth > 0
- active  out  channels  registered; one-hot-per-level in-service bits
- spurious_ret  out  1  registered one-cycle pulse: ret_int committed at depth 0

Behaviour:
- Reset (asynchronous, active-low) clears req_q, pending, active, depth, stack pointer, in_interrupt_context and spurious_ret. Combinational outputs are therefore 0.
- Edge capture runs every clk regardless of enable:
  - req_q <= interrupt_request.
  - pending[i] is set on interrupt_request[i] & ~req_q[i].
  - Pending is set independently of the mask and held until taken.
  - An edge seen at edge n can be taken at the earliest in the cycle after edge n.
- Eligibility: channel i is eligible if pending[i] & int_mask[i], and either active==0 or i < lowest set index of active.
- Selection: the winner is the lowest eligible index.
- take = enable & cpu_update & (any eligible). interrupt = take.
- On take:
  - out_routine = vector_base + winner*vector_stride, truncated to wordsize.
  - At the clock edge: push program_counter, set active[winner], clear pending[winner], depth+1.
  - If a new rising edge arrives on winner in the same cycle, set wins and pending stays 1.
- Return: ret = enable & cpu_update & ret_int & ~take & (depth>0).
  - Combinationally, out = stack top and out_reg = pc_id.
  - At the clock edge: pop, clear the lowest set bit of active, depth-1.
- Simultaneous take and ret_int: take wins and ret_int is ignored. The pushed PC is the return instruction's address, so the return re-executes later.
- ret_int with depth 0 (and no take): out=0, out_reg=0, spurious_ret=1 for one cycle. No other state change.
- Stack cannot overflow, because each level requires strictly higher priority, so depth <= channels. The implementation asserts this in simulation.
- Masking a channel while in service does not affect active or the stack. Unmasking lets a held pending request fire.
- Stack depth = channels entries of wordsize bits. Storage is not reset; only the pointer is.
- enable low: no take, no return. Pending accumulation continues.

Test Plan:
(All cases: wordsize=16, channels=4, vector_base=0x0100, stride=0x10, pc_id=1, mask=0xF, cpu_update=1 unless noted.)
1. Reset: assert reset=0 mid-routine at depth 2 -> all outputs 0 immediately. After release, no interrupt fires until a new edge occurs.
2. Single interrupt:
   - Stimulus: pulse req[2] with PC=0x0042.
   - Next cycle: interrupt=1, out_routine=0x0120.
   - Then: active=0100, in_interrupt_context=1.
   - ret_int -> out=0x0042, out_reg=1. Context drops to 0 the following cycle.
3. Nesting:
   - Stimulus: in ch2 routine (PC=0x0125), pulse req[1] and req[3].
   - ch1 is taken -> out_routine=0x0110, 0x0125 pushed. ch3 stays pending.
   - First ret -> out=0x0125.
   - Second ret, then ch3 fires -> out_routine=0x0130.
4. Mask/hold:
   - Stimulus: mask=1110, pulse req[0].
   - Required: no interrupt for 10 cycles.
   - Set mask=1111 -> interrupt=1, out_routine=0x0100.
   - Repeat with cpu_update=0 -> interrupt waits for cpu_update=1.
5. Simultaneous: in ch2 routine, ret_int=1 in the same cycle ch0 is eligible -> interrupt=1, out=0, depth becomes 2, saved PC = return address.
6. Spurious return / enable:
   - ret_int at depth 0 -> spurious_ret pulse, out=0.
   - With enable=0, a req[3] edge -> no interrupt. After enable=1, it fires with out_routine=0x0130.

Source files
------------

// File: rtl/reflet_interrupt_nested.sv
// rtl/reflet_interrupt_nested.sv - nested fixed-priority vectored interrupt controller
//
// Purpose:
//   Captures rising edges on the request lines into per-channel pending bits.
//   It redirects the CPU to a per-channel routine address when a higher-priority
//   channel than the one currently in service is pending and enabled. It keeps a
//   return-address stack so that routines can nest.
//   A committed return-from-interrupt pops the stack and hands the restored PC
//   to the CPU write-back path (out/out_reg).
//
// Ports:
//   clk                  system clock
//   reset                asynchronous active-low reset
//   enable               CPU enable; no take or return while low
//   interrupt_request    request lines, rising-edge sensitive
//   int_mask             1 = channel enabled
//   cpu_update           CPU commits an instruction this cycle
//   ret_int              committed instruction is return-from-interrupt
//   program_counter      resume address pushed when a routine is entered
//   interrupt            combinational redirect strobe
//   out_routine          routine address while interrupt=1, else 0
//   out                  restored PC during a return, else 0
//   out_reg              pc_id during a return, else 0
//   in_interrupt_context registered, 1 while the stack is non-empty
//   active               registered in-service bits, one per nesting level
//   spurious_ret         registered pulse: return committed with empty stack

module reflet_interrupt_nested #(
    parameter int wordsize      = 16,
    parameter int channels      = 4,
    parameter int vector_base   = 0,
    parameter int vector_stride = 16,
    parameter int pc_id         = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [channels-1:0] interrupt_request,
    input  logic [channels-1:0] int_mask,
    input  logic                cpu_update,
    input  logic                ret_int,
    input  logic [wordsize-1:0] program_counter,
    output logic                interrupt,
    output logic [wordsize-1:0] out_routine,
    output logic [wordsize-1:0] out,
    output logic [3:0]          out_reg,
    output logic                in_interrupt_context,
    output logic [channels-1:0] active,
    output logic                spurious_ret
);

    localparam int IDX_W   = (channels > 1) ? $clog2(channels) : 1;
    localparam int DEPTH_W = $clog2(channels + 1);

    logic [channels-1:0] r_req_q;
    logic [channels-1:0] r_pending;
    logic [channels-1:0] r_active;
    logic [DEPTH_W-1:0]  r_depth;
    logic                r_in_ctx;
    logic                r_spurious;
    logic [wordsize-1:0] r_stack [channels];

    logic [channels-1:0] w_edges;
    logic [channels-1:0] w_eligible;
    logic [channels-1:0] w_win_onehot;
    logic [IDX_W-1:0]    w_winner;
    logic                w_any;
    logic                w_take;
    logic                w_ret;
    logic                w_spur;
    logic                w_depth_nz;
    logic [DEPTH_W-1:0]  w_depth_next;
    logic [IDX_W-1:0]    w_top_idx;
    logic [IDX_W-1:0]    w_push_idx;
    logic [wordsize-1:0] w_top;

    assign w_edges = interrupt_request & ~r_req_q;

    // A channel may preempt only if its index is below every in-service bit,
    // so walk upward and stop allowing channels once an active bit is passed.
    always_comb begin
        logic w_blocked;
        w_blocked  = 1'b0;
        w_eligible = '0;
        for (int i = 0; i < channels; i++) begin
            w_blocked     = w_blocked | r_active[i];
            w_eligible[i] = r_pending[i] & int_mask[i] & ~w_blocked;
        end
    end

    // Scan downward so the last hit, the lowest index, wins.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        for (int i = channels - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_any    = 1'b1;
                w_winner = IDX_W'(i);
            end
        end
    end

    assign w_depth_nz   = (r_depth != '0);
    assign w_take       = enable & cpu_update & w_any;
    assign w_ret        = enable & cpu_update & ret_int & ~w_take & w_depth_nz;
    assign w_spur       = enable & cpu_update & ret_int & ~w_take & ~w_depth_nz;
    assign w_win_onehot = w_take ? (channels'(1) << w_winner) : '0;

    // The stack pointer is the depth itself: entry depth-1 is the top.
    assign w_top_idx  = IDX_W'(r_depth - DEPTH_W'(1));
    assign w_push_idx = IDX_W'(r_depth);
    assign w_top      = r_stack[w_top_idx];

    always_comb begin
        w_depth_next = r_depth;
        if (w_take) begin
            w_depth_next = r_depth + DEPTH_W'(1);
        end else if (w_ret) begin
            w_depth_next = r_depth - DEPTH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req_q    <= '0;
            r_pending  <= '0;
            r_active   <= '0;
            r_depth    <= '0;
            r_in_ctx   <= 1'b0;
            r_spurious <= 1'b0;
        end else begin
            r_req_q <= interrupt_request;
            // A fresh edge on the winner in its take cycle keeps it pending.
            r_pending <= (r_pending & ~w_win_onehot) | w_edges;
            if (w_take) begin
                r_active <= r_active | w_win_onehot;
            end else if (w_ret) begin
                // The innermost level always owns the lowest set bit.
                r_active <= r_active & (r_active - channels'(1));
            end
            r_depth    <= w_depth_next;
            r_in_ctx   <= (w_depth_next != '0);
            r_spurious <= w_spur;
        end
    end

    // Return-address storage carries no reset; only the depth pointer does.
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_stack[w_push_idx] <= program_counter;
        end
    end

    assign interrupt            = w_take;
    assign out_routine          = w_take ? (wordsize'(vector_base)
                                         + wordsize'(w_winner) * wordsize'(vector_stride))
                                         : '0;
    assign out                  = w_ret ? w_top : '0;
    assign out_reg              = w_ret ? 4'(pc_id) : 4'd0;
    assign in_interrupt_context = r_in_ctx;
    assign active               = r_active;
    assign spurious_ret         = r_spurious;

    // Each level needs strictly higher priority, so a push never finds the stack full.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        w_take |-> (r_depth < DEPTH_W'(channels)));

endmodule

// File: tb/tb_reflet_interrupt_nested.sv
// tb/tb_reflet_interrupt_nested.sv - self-checking bench for reflet_interrupt_nested

module tb_reflet_interrupt_nested;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  interrupt_request;
    logic [3:0]  int_mask;
    logic        cpu_update;
    logic        ret_int;
    logic [15:0] program_counter;
    logic        interrupt;
    logic [15:0] out_routine;
    logic [15:0] out;
    logic [3:0]  out_reg;
    logic        in_interrupt_context;
    logic [3:0]  active;
    logic        spurious_ret;

    int n_checks = 0;
    int n_errors = 0;

    reflet_interrupt_nested #(
        .wordsize(16), .channels(4), .vector_base(16'h0100),
        .vector_stride(16'h0010), .pc_id(1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .interrupt_request(interrupt_request), .int_mask(int_mask),
        .cpu_update(cpu_update), .ret_int(ret_int),
        .program_counter(program_counter), .interrupt(interrupt),
        .out_routine(out_routine), .out(out), .out_reg(out_reg),
        .in_interrupt_context(in_interrupt_context), .active(active),
        .spurious_ret(spurious_ret)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pending set, a stack of (channel, saved pc) entries.
    bit [3:0]    m_req_q, m_pend, m_edges, m_act;
    int          m_ch[$];
    logic [15:0] m_pc[$];
    bit          m_spur;
    int          m_win, m_lim;
    bit          m_take, m_ret, m_spur_n;

    always @(negedge clk) begin
        if (!reset) begin
            m_req_q = '0; m_pend = '0; m_spur = 0;
            m_ch.delete(); m_pc.delete();
            check("rst_interrupt", interrupt, 0);
            check("rst_routine", out_routine, 0);
            check("rst_out", out, 0);
            check("rst_out_reg", out_reg, 0);
            check("rst_active", active, 0);
            check("rst_ctx", in_interrupt_context, 0);
            check("rst_spur", spurious_ret, 0);
        end else begin
            m_lim = (m_ch.size() == 0) ? 4 : m_ch[m_ch.size()-1];
            m_win = -1;
            for (int i = 0; i < 4; i++)
                if (m_win < 0 && m_pend[i] && int_mask[i] && i < m_lim) m_win = i;
            m_take   = enable && cpu_update && (m_win >= 0);
            m_ret    = enable && cpu_update && ret_int && !m_take && m_ch.size() > 0;
            m_spur_n = enable && cpu_update && ret_int && !m_take && m_ch.size() == 0;
            m_act = '0;
            foreach (m_ch[k]) m_act[m_ch[k]] = 1'b1;

            check("m_interrupt", interrupt, m_take);
            check("m_routine", out_routine, m_take ? 32'(16'h0100 + m_win * 16'h0010) : 0);
            check("m_out", out, m_ret ? m_pc[m_pc.size()-1] : 0);
            check("m_out_reg", out_reg, m_ret ? 1 : 0);
            check("m_active", active, m_act);
            check("m_ctx", in_interrupt_context, m_ch.size() > 0);
            check("m_spur", spurious_ret, m_spur);

            m_edges = interrupt_request & ~m_req_q;
            if (m_take) begin
                m_pend[m_win] = 1'b0;
                m_ch.push_back(m_win);
                m_pc.push_back(program_counter);
            end else if (m_ret) begin
                void'(m_ch.pop_back());
                void'(m_pc.pop_back());
            end
            m_pend  = m_pend | m_edges;
            m_req_q = interrupt_request;
            m_spur  = m_spur_n;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 0; enable = 1; interrupt_request = 0; int_mask = 4'hF;
        cpu_update = 1; ret_int = 0; program_counter = 0;
        repeat (3) cyc();
        reset = 1;
        cyc();

        // Single interrupt
        program_counter = 16'h0042; interrupt_request = 4'b0100; cyc();
        interrupt_request = 0; #1;
        check("t2_int", interrupt, 1);
        check("t2_routine", out_routine, 16'h0120);
        cyc(); #1;
        check("t2_active", active, 4'b0100);
        check("t2_ctx", in_interrupt_context, 1);
        ret_int = 1; #1;
        check("t2_out", out, 16'h0042);
        check("t2_out_reg", out_reg, 1);
        cyc(); ret_int = 0; #1;
        check("t2_ctx_drop", in_interrupt_context, 0);

        // Nesting
        program_counter = 16'h0050; interrupt_request = 4'b0100; cyc();
        interrupt_request = 0; cyc();
        program_counter = 16'h0125; interrupt_request = 4'b1010; cyc();
        interrupt_request = 0; #1;
        check("t3_int1", interrupt, 1);
        check("t3_routine1", out_routine, 16'h0110);
        cyc(); #1;
        check("t3_active", active, 4'b0110);
        check("t3_ch3_blocked", interrupt, 0);
        program_counter = 16'h0115; ret_int = 1; #1;
        check("t3_ret1", out, 16'h0125);
        cyc(); #1;
        check("t3_active2", active, 4'b0100);
        check("t3_ch3_blocked2", interrupt, 0);
        check("t3_ret2", out, 16'h0050);
        cyc(); ret_int = 0; #1;
        check("t3_int3", interrupt, 1);
        check("t3_routine3", out_routine, 16'h0130);
        cyc(); ret_int = 1; #1;
        check("t3_ret3", out, 16'h0115);
        cyc(); ret_int = 0;

        // Mask / hold
        int_mask = 4'b1110; interrupt_request = 4'b0001; cyc();
        interrupt_request = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(); #1;
            check("t4_masked", interrupt, 0);
        end
        int_mask = 4'hF; #1;
        check("t4_unmask_int", interrupt, 1);
        check("t4_unmask_routine", out_routine, 16'h0100);
        cyc(); ret_int = 1; cyc(); ret_int = 0;
        int_mask = 4'b1110; interrupt_request = 4'b0001; cyc();
        interrupt_request = 0; cyc();
        int_mask = 4'hF; cpu_update = 0; #1;
        check("t4_noupd", interrupt, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            check("t4_noupd_hold", interrupt, 0);
        end
        cpu_update = 1; #1;
        check("t4_upd_int", interrupt, 1);
        check("t4_upd_routine", out_routine, 16'h0100);
        cyc(); ret_int = 1; cyc(); ret_int = 0;

        // Simultaneous take and return
        program_counter = 16'h0060; interrupt_request = 4'b0100; cyc();
        interrupt_request = 0; cyc();
        program_counter = 16'h0123; interrupt_request = 4'b0001; cyc();
        interrupt_request = 0; program_counter = 16'h0124; ret_int = 1; #1;
        check("t5_int", interrupt, 1);
        check("t5_routine", out_routine, 16'h0100);
        check("t5_out", out, 0);
        check("t5_out_reg", out_reg, 0);
        cyc(); #1;
        check("t5_active", active, 4'b0101);
        check("t5_ret_addr", out, 16'h0124);
        check("t5_out_reg2", out_reg, 1);
        cyc(); #1;
        check("t5_ret_outer", out, 16'h0060);
        cyc(); ret_int = 0; #1;
        check("t5_ctx", in_interrupt_context, 0);

        // Spurious return and enable
        ret_int = 1; #1;
        check("t6_out", out, 0);
        check("t6_out_reg", out_reg, 0);
        cyc(); ret_int = 0; #1;
        check("t6_spur", spurious_ret, 1);
        cyc(); #1;
        check("t6_spur_end", spurious_ret, 0);
        enable = 0; interrupt_request = 4'b1000; cyc();
        interrupt_request = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            check("t6_disabled", interrupt, 0);
        end
        enable = 1; #1;
        check("t6_en_int", interrupt, 1);
        check("t6_en_routine", out_routine, 16'h0130);
        cyc(); ret_int = 1; cyc(); ret_int = 0;

        // Reset mid-routine at depth 2
        program_counter = 16'h0033; interrupt_request = 4'b0100; cyc();
        interrupt_request = 0; cyc();
        program_counter = 16'h0070; interrupt_request = 4'b0010; cyc();
        interrupt_request = 0; cyc();
        ret_int = 1; #1;
        check("t1_pre_out", out, 16'h0070);
        check("t1_pre_active", active, 4'b0110);
        #1 reset = 0; #1;
        check("t1_out", out, 0);
        check("t1_out_reg", out_reg, 0);
        check("t1_active", active, 0);
        check("t1_ctx", in_interrupt_context, 0);
        check("t1_int", interrupt, 0);
        ret_int = 0; cyc(); cyc();
        reset = 1;
        for (int i = 0; i < 5; i++) begin
            cyc(); #1;
            check("t1_quiet", interrupt, 0);
        end

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cyc();
            if ($urandom_range(0, 5) == 0)
                interrupt_request = interrupt_request ^ (4'b0001 << $urandom_range(0, 3));
            int_mask        = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
            cpu_update      = ($urandom_range(0, 3) != 0);
            ret_int         = ($urandom_range(0, 2) == 0);
            enable          = ($urandom_range(0, 9) != 0);
            program_counter = 16'($urandom);
            reset           = ($urandom_range(0, 499) != 0);
        end
        cyc();
        reset = 1;
        repeat (2) cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
